// File: rtl/riscv_core_pkg.sv
// Shared types and constants for the RF write-back arbiter and its scoreboard.
package riscv_core_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned XLEN       = 32;

    typedef enum logic {WBA_IDLE, WBA_HOLD} wba_state_e;

    function automatic logic rd_nz(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/riscv_core_wba_scoreboard.sv
// Tracks registers with a divide in flight, the outstanding divide count and
// protocol errors; raises the decode stall on RAW/WAW hazards.
module riscv_core_wba_scoreboard
    import riscv_core_pkg::*;
#(
    parameter int unsigned MAX_OUT = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issue_i,
    input  logic [REG_ADDR_W-1:0] issue_rd_i,
    input  logic                  result_i,
    input  logic                  retire_i,
    input  logic [REG_ADDR_W-1:0] retire_rd_i,
    input  logic [REG_ADDR_W-1:0] rs1_i,
    input  logic [REG_ADDR_W-1:0] rs2_i,
    input  logic [REG_ADDR_W-1:0] id_rd_i,
    input  logic                  id_we_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  id_stall_o,
    output logic                  err_o
);
    localparam int unsigned NREG  = 2 ** REG_ADDR_W;
    localparam int unsigned CNT_W = $clog2(MAX_OUT + 1);

    logic [NREG-1:0]  pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             full, empty, issue_ok, dec_ok, hazard;

    assign full     = cnt_q == CNT_W'(MAX_OUT);
    assign empty    = cnt_q == '0;
    assign issue_ok = issue_i & ~full;
    assign dec_ok   = retire_i & ~empty;

    always_comb begin
        pend_d = pend_q;
        if (retire_i) begin
            pend_d[retire_rd_i] = 1'b0;
        end
        // A new issue to the register being retired this cycle must stay pending.
        if (issue_ok && rd_nz(issue_rd_i)) begin
            pend_d[issue_rd_i] = 1'b1;
        end
        pend_d[0] = 1'b0;

        cnt_d = cnt_q;
        case ({issue_ok, dec_ok})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        err_d = err_q | (issue_i & full) | (result_i & empty);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q <= '0;
            cnt_q  <= '0;
            err_q  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

    assign hazard = (rd_nz(rs1_i) & pend_q[rs1_i])
                  | (rd_nz(rs2_i) & pend_q[rs2_i])
                  | (id_we_i & rd_nz(id_rd_i) & pend_q[id_rd_i]);

    assign id_stall_o = ~rst_i & hazard;
    assign full_o     = ~rst_i & full;
    assign empty_o    = empty;
    assign err_o      = err_q;

endmodule

// File: rtl/riscv_core_rf_wb_arb.sv
// Shares the single RF write port between pipeline WB and out-of-band divider
// results, with a one-entry hold buffer and a starvation bound.
module riscv_core_rf_wb_arb
    import riscv_core_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned MAX_OUT    = 2,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  i_wba_clk,
    input  logic                  i_wba_rst,
    input  logic                  i_wba_pl_we,
    input  logic [REG_ADDR_W-1:0] i_wba_pl_rd,
    input  logic [XLEN-1:0]       i_wba_pl_wd,
    output logic                  o_wba_wb_stall,
    input  logic                  i_wba_md_issue,
    input  logic [REG_ADDR_W-1:0] i_wba_md_issue_rd,
    output logic                  o_wba_md_full,
    input  logic                  i_wba_md_valid,
    input  logic [REG_ADDR_W-1:0] i_wba_md_rd,
    input  logic [XLEN-1:0]       i_wba_md_wd,
    output logic                  o_wba_md_ready,
    input  logic [REG_ADDR_W-1:0] i_wba_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_wba_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_wba_id_rd,
    input  logic                  i_wba_id_we,
    output logic                  o_wba_id_stall,
    output logic                  o_wba_rf_we3,
    output logic [REG_ADDR_W-1:0] o_wba_rf_a3,
    output logic [XLEN-1:0]       o_wba_rf_wd3,
    output logic                  o_wba_err
);
    localparam int unsigned ST_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    wba_state_e            state_q, state_d;
    logic [REG_ADDR_W-1:0] hold_rd_q, hold_rd_d;
    logic [XLEN-1:0]       hold_wd_q, hold_wd_d;
    logic [ST_W-1:0]       starve_q, starve_d;

    logic                  pl_req, sb_empty, retire;
    logic [REG_ADDR_W-1:0] retire_rd;

    assign pl_req = i_wba_pl_we & rd_nz(i_wba_pl_rd);

    always_comb begin
        state_d        = state_q;
        hold_rd_d      = hold_rd_q;
        hold_wd_d      = hold_wd_q;
        starve_d       = starve_q;
        o_wba_rf_we3   = pl_req;
        o_wba_rf_a3    = i_wba_pl_rd;
        o_wba_rf_wd3   = i_wba_pl_wd;
        o_wba_wb_stall = 1'b0;
        o_wba_md_ready = 1'b0;
        retire         = 1'b0;
        retire_rd      = i_wba_md_rd;

        case (state_q)
            WBA_IDLE: begin
                o_wba_md_ready = 1'b1;
                // Results with nothing outstanding are dropped; rd 0 retires without a write.
                if (i_wba_md_valid && !sb_empty) begin
                    if (!rd_nz(i_wba_md_rd)) begin
                        retire = 1'b1;
                    end else if (!pl_req) begin
                        o_wba_rf_we3 = 1'b1;
                        o_wba_rf_a3  = i_wba_md_rd;
                        o_wba_rf_wd3 = i_wba_md_wd;
                        retire       = 1'b1;
                    end else begin
                        hold_rd_d = i_wba_md_rd;
                        hold_wd_d = i_wba_md_wd;
                        starve_d  = '0;
                        state_d   = WBA_HOLD;
                    end
                end
            end
            WBA_HOLD: begin
                if (pl_req && (starve_q < ST_W'(STARVE_MAX))) begin
                    starve_d = starve_q + 1'b1;
                end else begin
                    o_wba_rf_we3   = 1'b1;
                    o_wba_rf_a3    = hold_rd_q;
                    o_wba_rf_wd3   = hold_wd_q;
                    o_wba_wb_stall = pl_req;
                    retire         = 1'b1;
                    retire_rd      = hold_rd_q;
                    state_d        = WBA_IDLE;
                end
            end
            default: state_d = WBA_IDLE;
        endcase

        if (i_wba_rst) begin
            o_wba_rf_we3   = 1'b0;
            o_wba_wb_stall = 1'b0;
            o_wba_md_ready = 1'b0;
            retire         = 1'b0;
        end
    end

    always_ff @(posedge i_wba_clk) begin
        if (i_wba_rst) begin
            state_q   <= WBA_IDLE;
            hold_rd_q <= '0;
            hold_wd_q <= '0;
            starve_q  <= '0;
        end else begin
            state_q   <= state_d;
            hold_rd_q <= hold_rd_d;
            hold_wd_q <= hold_wd_d;
            starve_q  <= starve_d;
        end
    end

    riscv_core_wba_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) u_sb (
        .clk_i       (i_wba_clk),
        .rst_i       (i_wba_rst),
        .issue_i     (i_wba_md_issue),
        .issue_rd_i  (i_wba_md_issue_rd),
        .result_i    (i_wba_md_valid & o_wba_md_ready),
        .retire_i    (retire),
        .retire_rd_i (retire_rd),
        .rs1_i       (i_wba_id_rs1),
        .rs2_i       (i_wba_id_rs2),
        .id_rd_i     (i_wba_id_rd),
        .id_we_i     (i_wba_id_we),
        .full_o      (o_wba_md_full),
        .empty_o     (sb_empty),
        .id_stall_o  (o_wba_id_stall),
        .err_o       (o_wba_err)
    );

endmodule

// File: tb/tb_riscv_core_rf_wb_arb.sv
// Self-checking bench: per-cycle RF write expectations queued as stimulus is driven.
module tb_riscv_core_rf_wb_arb;

    logic        clk, rst;
    logic        pl_we, md_issue, md_valid, id_we;
    logic [4:0]  pl_rd, md_issue_rd, md_rd, id_rs1, id_rs2, id_rd;
    logic [31:0] pl_wd, md_wd;
    logic        wb_stall, md_full, md_ready, id_stall, rf_we3, err;
    logic [4:0]  rf_a3;
    logic [31:0] rf_wd3;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] wd;
    } wr_t;
    wr_t exp_q[$];

    int checks = 0;
    int errors = 0;

    riscv_core_rf_wb_arb dut (
        .i_wba_clk         (clk),
        .i_wba_rst         (rst),
        .i_wba_pl_we       (pl_we),
        .i_wba_pl_rd       (pl_rd),
        .i_wba_pl_wd       (pl_wd),
        .o_wba_wb_stall    (wb_stall),
        .i_wba_md_issue    (md_issue),
        .i_wba_md_issue_rd (md_issue_rd),
        .o_wba_md_full     (md_full),
        .i_wba_md_valid    (md_valid),
        .i_wba_md_rd       (md_rd),
        .i_wba_md_wd       (md_wd),
        .o_wba_md_ready    (md_ready),
        .i_wba_id_rs1      (id_rs1),
        .i_wba_id_rs2      (id_rs2),
        .i_wba_id_rd       (id_rd),
        .i_wba_id_we       (id_we),
        .o_wba_id_stall    (id_stall),
        .o_wba_rf_we3      (rf_we3),
        .o_wba_rf_a3       (rf_a3),
        .o_wba_rf_wd3      (rf_wd3),
        .o_wba_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clr_in();
        pl_we = 0; pl_rd = 0; pl_wd = 0;
        md_issue = 0; md_issue_rd = 0;
        md_valid = 0; md_rd = 0; md_wd = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_we = 0;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] wd);
        wr_t e;
        e.rd = rd; e.wd = wd;
        exp_q.push_back(e);
    endtask

    // Mid-cycle sample: compare the RF port against this cycle's expectation.
    task automatic sample();
        wr_t e;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            if (rf_we3 !== 1'b1 || rf_a3 !== e.rd || rf_wd3 !== e.wd) begin
                errors++;
                $display("FAIL rf_write t=%0t got we3=%b a3=%0d wd3=%h need we3=1 a3=%0d wd3=%h",
                         $time, rf_we3, rf_a3, rf_wd3, e.rd, e.wd);
            end
        end else if (rf_we3 !== 1'b0) begin
            errors++;
            $display("FAIL rf_idle t=%0t got we3=%b a3=%0d need we3=0", $time, rf_we3, rf_a3);
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1; clr_in();
        pl_we = 1; pl_rd = 3; pl_wd = 32'h55;
        md_valid = 1; md_rd = 4; md_issue = 1; md_issue_rd = 6; id_rs1 = 6;
        adv(); sample();
        checks++;
        if ({rf_we3, md_ready, wb_stall, id_stall, md_full, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outs got we3,rdy,wbst,idst,full,err=%b need 000000",
                     {rf_we3, md_ready, wb_stall, id_stall, md_full, err});
        end
        adv();
        rst = 0; clr_in(); id_rs1 = 6;
        sample();
        checks++;
        if ({md_ready, id_stall, md_full, err} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_release got rdy,idst,full,err=%b need 1000",
                     {md_ready, id_stall, md_full, err});
        end
        adv();
    endtask

    task automatic test_idle_port();
        clr_in(); md_issue = 1; md_issue_rd = 5;
        sample(); adv();
        clr_in(); md_valid = 1; md_rd = 5; md_wd = 32'h1234; id_rs1 = 5;
        expect_wr(5, 32'h1234);
        sample();
        checks++;
        if ({md_ready, wb_stall, id_stall} !== 3'b101) begin
            errors++;
            $display("FAIL idle_direct got rdy,wbst,idst=%b need 101", {md_ready, wb_stall, id_stall});
        end
        adv();
        clr_in(); id_rs1 = 5;
        sample();
        checks++;
        if (id_stall !== 1'b0) begin
            errors++;
            $display("FAIL idle_clear got id_stall=%b need 0", id_stall);
        end
        adv();
    endtask

    task automatic test_collision();
        clr_in(); md_issue = 1; md_issue_rd = 7;
        sample(); adv();
        clr_in(); pl_we = 1; pl_rd = 3; pl_wd = 32'hA;
        md_valid = 1; md_rd = 7; md_wd = 32'h77;
        expect_wr(3, 32'hA);
        sample(); adv();
        clr_in();
        expect_wr(7, 32'h77);
        sample();
        checks++;
        if ({md_ready, wb_stall} !== 2'b00) begin
            errors++;
            $display("FAIL collide_drain got rdy,wbst=%b need 00", {md_ready, wb_stall});
        end
        adv();
        sample();
        checks++;
        if (md_ready !== 1'b1) begin
            errors++;
            $display("FAIL collide_idle got md_ready=%b need 1", md_ready);
        end
        adv();
    endtask

    task automatic test_starvation();
        clr_in(); md_issue = 1; md_issue_rd = 9;
        sample(); adv();
        clr_in(); pl_we = 1; pl_rd = 1; pl_wd = 32'd100;
        md_valid = 1; md_rd = 9; md_wd = 32'h99;
        expect_wr(1, 32'd100);
        sample(); adv();
        for (int i = 0; i < 4; i++) begin
            clr_in(); pl_we = 1; pl_rd = 2; pl_wd = 32'd200 + i;
            expect_wr(2, 32'd200 + i);
            sample();
            checks++;
            if ({wb_stall, md_ready} !== 2'b00) begin
                errors++;
                $display("FAIL starve_pl%0d got wbst,rdy=%b need 00", i, {wb_stall, md_ready});
            end
            adv();
        end
        clr_in(); pl_we = 1; pl_rd = 2; pl_wd = 32'd300;
        expect_wr(9, 32'h99);
        sample();
        checks++;
        if (wb_stall !== 1'b1) begin
            errors++;
            $display("FAIL starve_force got wb_stall=%b need 1", wb_stall);
        end
        adv();
        expect_wr(2, 32'd300);
        sample();
        checks++;
        if ({wb_stall, md_ready} !== 2'b01) begin
            errors++;
            $display("FAIL starve_retry got wbst,rdy=%b need 01", {wb_stall, md_ready});
        end
        adv();
    endtask

    task automatic test_scoreboard();
        clr_in(); md_issue = 1; md_issue_rd = 10; id_rs2 = 10;
        sample();
        checks++;
        if (id_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_issue_cycle got id_stall=%b need 0", id_stall);
        end
        adv();
        clr_in(); id_rs2 = 10;
        sample();
        checks++;
        if (id_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_raw got id_stall=%b need 1", id_stall);
        end
        #1 id_rs2 = 0; id_we = 1; id_rd = 10;
        #1 checks++;
        if (id_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_waw got id_stall=%b need 1", id_stall);
        end
        #1 id_we = 0;
        #1 checks++;
        if (id_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_rd_nowe got id_stall=%b need 0", id_stall);
        end
        adv();
        clr_in(); md_valid = 1; md_rd = 10; md_wd = 32'hAAAA; id_rs2 = 10;
        expect_wr(10, 32'hAAAA);
        sample();
        checks++;
        if (id_stall !== 1'b1) begin
            errors++;
            $display("FAIL sb_wr_cycle got id_stall=%b need 1", id_stall);
        end
        adv();
        clr_in(); id_rs2 = 10;
        sample();
        checks++;
        if (id_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_after_wr got id_stall=%b need 0", id_stall);
        end
        adv();
        // Same-cycle issue and retire of r12: pending must survive.
        clr_in(); md_issue = 1; md_issue_rd = 12;
        sample(); adv();
        clr_in(); md_issue = 1; md_issue_rd = 12; md_valid = 1; md_rd = 12; md_wd = 32'hC;
        expect_wr(12, 32'hC);
        sample(); adv();
        clr_in(); id_rs1 = 12;
        sample();
        checks++;
        if ({id_stall, md_full} !== 2'b10) begin
            errors++;
            $display("FAIL sb_set_wins got idst,full=%b need 10", {id_stall, md_full});
        end
        adv();
        clr_in(); md_valid = 1; md_rd = 12; md_wd = 32'hD;
        expect_wr(12, 32'hD);
        sample(); adv();
        clr_in(); id_rs1 = 12;
        sample();
        checks++;
        if (id_stall !== 1'b0) begin
            errors++;
            $display("FAIL sb_set_clear got id_stall=%b need 0", id_stall);
        end
        adv();
    endtask

    task automatic test_capacity();
        clr_in(); md_issue = 1; md_issue_rd = 13;
        sample(); adv();
        clr_in(); md_issue = 1; md_issue_rd = 14;
        sample();
        checks++;
        if (md_full !== 1'b0) begin
            errors++;
            $display("FAIL cap_one got md_full=%b need 0", md_full);
        end
        adv();
        clr_in(); md_issue = 1; md_issue_rd = 15;
        sample();
        checks++;
        if ({md_full, err} !== 2'b10) begin
            errors++;
            $display("FAIL cap_full got full,err=%b need 10", {md_full, err});
        end
        adv();
        clr_in(); id_rs1 = 15;
        sample();
        checks++;
        if ({md_full, err, id_stall} !== 3'b110) begin
            errors++;
            $display("FAIL cap_over got full,err,idst=%b need 110", {md_full, err, id_stall});
        end
        adv();
        clr_in(); md_valid = 1; md_rd = 13; md_wd = 32'h1;
        expect_wr(13, 32'h1);
        sample(); adv();
        clr_in();
        sample();
        checks++;
        if (md_full !== 1'b0) begin
            errors++;
            $display("FAIL cap_free got md_full=%b need 0", md_full);
        end
        adv();
        clr_in(); md_valid = 1; md_rd = 14; md_wd = 32'h2;
        expect_wr(14, 32'h2);
        sample(); adv();
        // Nothing outstanding: this result must be dropped without a write.
        clr_in(); md_valid = 1; md_rd = 16; md_wd = 32'h3;
        sample(); adv();
        clr_in(); md_issue = 1; md_issue_rd = 0;
        sample(); adv();
        clr_in(); md_valid = 1; md_rd = 0; md_wd = 32'h4; pl_we = 1; pl_rd = 4; pl_wd = 32'h5;
        expect_wr(4, 32'h5);
        sample(); adv();
        clr_in(); md_issue = 1; md_issue_rd = 21;
        sample();
        checks++;
        if (md_ready !== 1'b1) begin
            errors++;
            $display("FAIL cap_rd0_nohold got md_ready=%b need 1", md_ready);
        end
        adv();
        clr_in(); md_issue = 1; md_issue_rd = 22;
        sample();
        checks++;
        if (md_full !== 1'b0) begin
            errors++;
            $display("FAIL cap_rd0_count got md_full=%b need 0", md_full);
        end
        adv();
        clr_in(); md_valid = 1; md_rd = 21; md_wd = 32'h21;
        expect_wr(21, 32'h21);
        sample(); adv();
        clr_in(); md_valid = 1; md_rd = 22; md_wd = 32'h22;
        expect_wr(22, 32'h22);
        sample(); adv();
    endtask

    task automatic test_reset_hold();
        clr_in(); md_issue = 1; md_issue_rd = 20;
        sample(); adv();
        clr_in(); pl_we = 1; pl_rd = 1; pl_wd = 32'h1;
        md_valid = 1; md_rd = 20; md_wd = 32'h2020;
        expect_wr(1, 32'h1);
        sample(); adv();
        rst = 1; clr_in();
        sample();
        checks++;
        if (md_ready !== 1'b0) begin
            errors++;
            $display("FAIL rsthold_rst got md_ready=%b need 0", md_ready);
        end
        adv();
        rst = 0; clr_in(); id_rs1 = 20;
        sample();
        checks++;
        if ({md_ready, id_stall, err, md_full} !== 4'b1000) begin
            errors++;
            $display("FAIL rsthold_release got rdy,idst,err,full=%b need 1000",
                     {md_ready, id_stall, err, md_full});
        end
        adv();
        clr_in();
        sample(); adv();
    endtask

    initial begin
        test_reset();
        test_idle_port();
        test_collision();
        test_starvation();
        test_scoreboard();
        test_capacity();
        test_reset_hold();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending writes need 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
